// File: rtl/median_window_sorter.sv
// 3x3 window median: captures nine offset-addressed pixels, runs a 9-pass
// odd-even transposition sort (one pass per cycle), presents entry 4 on valid/ready.
//   state   | meaning
//   COLLECT | capturing window samples into win/mask
//   SORT    | passes 0..8, then one cycle to register the median
//   OUT     | median held until median_ready_i
module median_window_sorter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_data_i,
  input  logic [1:0]        count_x_i,
  input  logic [1:0]        count_y_i,
  output logic              median_valid_o,
  input  logic              median_ready_i,
  output logic [DATA_W-1:0] median_data_o,
  output logic              busy_o,
  output logic              seq_error_o
);

  typedef enum logic [1:0] {COLLECT, SORT, OUT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [8:0]        mask_q, mask_d;
  logic [3:0]        pass_q, pass_d;
  logic              mvalid_q, mvalid_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              err_q, err_d;

  logic [1:0] x_u, y_u;
  logic [3:0] idx;
  logic       illegal;

  assign x_u     = count_x_i + 2'd1;
  assign y_u     = count_y_i + 2'd1;
  assign idx     = ({2'b00, y_u} * 4'd3) + {2'b00, x_u};
  assign illegal = (count_x_i == 2'b10) || (count_y_i == 2'b10);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    err_d    = 1'b0;
    for (int i = 0; i < 9; i++) win_d[i] = win_q[i];

    case (state_q)
      COLLECT: begin
        if (pix_valid_i) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            win_d[idx] = pix_data_i;
            if (idx == 4'd8) begin
              if (&mask_q[7:0]) begin
                mask_d[8] = 1'b1;
                state_d   = SORT;
                pass_d    = 4'd0;
              end else begin
                err_d  = 1'b1;
                mask_d = '0;
              end
            end else begin
              mask_d[idx] = 1'b1;
            end
          end
        end
      end
      SORT: begin
        err_d = pix_valid_i;
        // pass_q==9 is the extra cycle that registers the fully sorted median
        if (pass_q == 4'd9) begin
          mdata_d  = win_q[4];
          mvalid_d = 1'b1;
          state_d  = OUT;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (((i % 2) == 1) == pass_q[0]) begin
              if (win_q[i] > win_q[i+1]) begin
                win_d[i]   = win_q[i+1];
                win_d[i+1] = win_q[i];
              end
            end
          end
          pass_d = pass_q + 4'd1;
        end
      end
      OUT: begin
        err_d = pix_valid_i;
        if (median_ready_i) begin
          mvalid_d = 1'b0;
          mask_d   = '0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      mask_q   <= '0;
      pass_q   <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pass_q   <= pass_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      err_q    <= err_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  assign median_valid_o = mvalid_q;
  assign median_data_o  = mdata_q;
  assign busy_o         = (state_q != COLLECT);
  assign seq_error_o    = err_q;

endmodule

// File: tb/tb_median_window_sorter.sv
// Directed bench for median_window_sorter: table of windows with hand-computed
// medians plus sequences for backpressure, incomplete window, illegal offset, overrun, reset.
module tb_median_window_sorter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [1:0] count_x, count_y;
  logic       median_valid, median_ready;
  logic [7:0] median_data;
  logic       busy, seq_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  median_window_sorter #(.DATA_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_valid_i    (pix_valid),
    .pix_data_i     (pix_data),
    .count_x_i      (count_x),
    .count_y_i      (count_y),
    .median_valid_o (median_valid),
    .median_ready_i (median_ready),
    .median_data_o  (median_data),
    .busy_o         (busy),
    .seq_error_o    (seq_error)
  );

  typedef struct {
    logic [7:0] px [9];
    logic [7:0] med;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_idx(input int idx, input logic [7:0] d);
    pix_valid = 1'b1;
    pix_data  = d;
    count_x   = 2'(idx % 3) - 2'b01;
    count_y   = 2'(idx / 3) - 2'b01;
    step();
    pix_valid = 1'b0;
  endtask

  // Expects median_ready=1; checks exact 10-cycle latency and one-cycle valid.
  task automatic run_window(input string nm, input logic [7:0] px [9], input logic [7:0] med);
    logic early;
    for (int i = 0; i < 9; i++) send_idx(i, px[i]);
    chk({nm, " busy_after_T"}, 32'(busy), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (median_valid) early = 1'b1;
    end
    chk({nm, " no_early_valid"}, 32'(early), 32'd0);
    step();
    chk({nm, " valid_T10"}, 32'(median_valid), 32'd1);
    chk({nm, " median"}, 32'(median_data), 32'(med));
    step();
    chk({nm, " valid_dropped"}, 32'(median_valid), 32'd0);
    chk({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] w [9];
    logic       seen;

    vecs[0].px = '{8'd10, 8'd200, 8'd30, 8'd40, 8'd250, 8'd60, 8'd70, 8'd0, 8'd90};   vecs[0].med = 8'd60;
    vecs[1].px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};               vecs[1].med = 8'd5;
    vecs[2].px = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};               vecs[2].med = 8'd5;
    vecs[3].px = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};      vecs[3].med = 8'hFF;
    vecs[4].px = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};       vecs[4].med = 8'd0;
    vecs[5].px = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};     vecs[5].med = 8'd255;
    vecs[6].px = '{8'd100, 8'd20, 8'd100, 8'd20, 8'd50, 8'd80, 8'd30, 8'd90, 8'd40};    vecs[6].med = 8'd50;

    reset = 1'b1; pix_valid = 1'b0; pix_data = '0; count_x = '0; count_y = '0;
    median_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst valid", 32'(median_valid), 32'd0);
    chk("rst data", 32'(median_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst seq_error", 32'(seq_error), 32'd0);

    for (int v = 0; v < 7; v++) run_window($sformatf("vec%0d", v), vecs[v].px, vecs[v].med);

    // backpressure
    median_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_idx(i, 8'hFF);
    for (int k = 1; k <= 10; k++) step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp valid hold%0d", k), 32'(median_valid), 32'd1);
      chk($sformatf("bp data hold%0d", k), 32'(median_data), 32'hFF);
      chk($sformatf("bp busy hold%0d", k), 32'(busy), 32'd1);
      if (k < 4) step();
    end
    median_ready = 1'b1;
    step();
    chk("bp valid drop", 32'(median_valid), 32'd0);
    chk("bp busy drop", 32'(busy), 32'd0);

    // incomplete window: idx 0..3 then idx 8
    for (int i = 0; i < 4; i++) send_idx(i, 8'd77);
    chk("inc no_err_early", 32'(seq_error), 32'd0);
    send_idx(8, 8'd77);
    chk("inc seq_error", 32'(seq_error), 32'd1);
    step();
    chk("inc err_single", 32'(seq_error), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (median_valid || busy) seen = 1'b1;
    end
    chk("inc no_median", 32'(seen), 32'd0);
    run_window("inc_next", vecs[1].px, 8'd5);

    // illegal offset lands on would-be idx 6; a write would turn median 60 into 40
    for (int i = 0; i < 7; i++) send_idx(i, vecs[0].px[i]);
    pix_valid = 1'b1; pix_data = 8'd0; count_x = 2'b10; count_y = 2'b00;
    step();
    pix_valid = 1'b0;
    chk("ill seq_error", 32'(seq_error), 32'd1);
    send_idx(7, vecs[0].px[7]);
    chk("ill err_clear", 32'(seq_error), 32'd0);
    send_idx(8, vecs[0].px[8]);
    chk("ill busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 10; k++) step();
    chk("ill valid", 32'(median_valid), 32'd1);
    chk("ill median", 32'(median_data), 32'd60);
    step();

    // overrun during SORT
    for (int i = 0; i < 9; i++) send_idx(i, vecs[0].px[i]);
    for (int k = 1; k <= 3; k++) begin
      pix_valid = 1'b1; pix_data = 8'd255; count_x = 2'b00; count_y = 2'b00;
      step();
      chk($sformatf("ovr seq_error%0d", k), 32'(seq_error), 32'd1);
    end
    pix_valid = 1'b0;
    step();
    chk("ovr err_clear", 32'(seq_error), 32'd0);
    for (int k = 5; k <= 10; k++) step();
    chk("ovr valid", 32'(median_valid), 32'd1);
    chk("ovr median", 32'(median_data), 32'd60);
    step();
    chk("ovr done", 32'(median_valid), 32'd0);

    // reset at pass 4 (pass 4 would execute on edge T+5)
    w = vecs[0].px;
    for (int i = 0; i < 9; i++) send_idx(i, w[i]);
    for (int k = 1; k <= 4; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid valid", 32'(median_valid), 32'd0);
    chk("rst_mid data", 32'(median_data), 32'd0);
    run_window("rst_next", vecs[2].px, 8'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached, expected finish earlier");
    $fatal(1);
  end

endmodule
